// File: rtl/uno_seq_ctrl.sv
// Command sequencer for one uno PE: walks MAC streams and nonlinear Horner
// evaluations, waits out the MAC latency and returns the result. Optional: UNO_SEQ_CTRL_PERF_EN.
module uno_seq_ctrl #(
  parameter int DW        = 12,
  parameter int CNT_W     = 4,
  parameter int MAC_LAT   = 1,
  parameter int DEF_ORDER = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cfg_we_i,
  input  logic [1:0]         cfg_op_i,
  input  logic [CNT_W-1:0]   cfg_order_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [CNT_W-1:0]   cmd_len_i,
  input  logic               opnd_valid_i,
  output logic               opnd_ready_o,
  output logic [1:0]         pe_op_o,
  output logic               pe_first_cycle_o,
  output logic               pe_last_cycle_o,
  output logic               pe_acc_en_o,
  output logic               pe_zero_x_o,
  output logic [CNT_W+1:0]   pe_coeff_addr_o,
  input  logic [2*DW-1:0]    pe_result_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [2*DW-1:0]    res_data_o,
  output logic               busy_o,
  input  logic               perf_clr_i,
  output logic [15:0]        perf_busy_o,
  output logic [15:0]        perf_stall_o
);
  localparam int DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {IDLE, MAC_RUN, NL_RUN, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, lim_q, lim_d;
  logic [DRN_W-1:0]      drn_q, drn_d;
  logic [2*DW-1:0]       res_q, res_d;
  logic [3:1][CNT_W-1:0] ord_q;
  logic [CNT_W-1:0]      cfg_val, nl_t;

  // Fewer than two terms is meaningless for Horner, so clamp on write.
  assign cfg_val = (cfg_order_i < CNT_W'(2)) ? CNT_W'(2) : cfg_order_i;

  always_comb begin
    unique case (cmd_op_i)
      2'd1:    nl_t = ord_q[1];
      2'd2:    nl_t = ord_q[2];
      default: nl_t = ord_q[3];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      lim_q   <= '0;
      drn_q   <= '0;
      res_q   <= '0;
      for (int i = 1; i <= 3; i++) ord_q[i] <= CNT_W'(DEF_ORDER);
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      drn_q   <= drn_d;
      res_q   <= res_d;
      for (int i = 1; i <= 3; i++)
        if (cfg_we_i && cfg_op_i == 2'(i)) ord_q[i] <= cfg_val;
    end
  end

  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    cnt_d            = cnt_q;
    lim_d            = lim_q;
    drn_d            = drn_q;
    res_d            = res_q;
    cmd_ready_o      = 1'b0;
    opnd_ready_o     = 1'b0;
    pe_first_cycle_o = 1'b0;
    pe_last_cycle_o  = 1'b0;
    pe_acc_en_o      = 1'b0;
    pe_zero_x_o      = 1'b1;
    pe_coeff_addr_o  = '0;
    res_valid_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          op_d  = cmd_op_i;
          cnt_d = '0;
          drn_d = '0;
          if (cmd_op_i == 2'd0) begin
            lim_d   = cmd_len_i;
            state_d = MAC_RUN;
          end else begin
            lim_d   = nl_t - CNT_W'(1);
            state_d = NL_RUN;
          end
        end
      end
      MAC_RUN: begin
        // cnt_q counts beats already fired; acc stays on through stalls after beat 0
        opnd_ready_o = 1'b1;
        pe_zero_x_o  = ~opnd_valid_i;
        pe_acc_en_o  = (cnt_q != '0);
        if (opnd_valid_i) begin
          if (cnt_q == lim_q) state_d = DRAIN;
          else                cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      NL_RUN: begin
        pe_zero_x_o      = 1'b0;
        pe_first_cycle_o = (cnt_q == '0);
        pe_last_cycle_o  = (cnt_q == lim_q);
        pe_coeff_addr_o  = {op_q, lim_q - cnt_q};
        if (cnt_q == lim_q) state_d = DRAIN;
        else                cnt_d   = cnt_q + CNT_W'(1);
      end
      DRAIN: begin
        if (drn_q == DRN_W'(MAC_LAT - 1)) begin
          res_d   = pe_result_i;
          state_d = DONE;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pe_op_o    = op_q;
  assign res_data_o = res_q;
  assign busy_o     = (state_q != IDLE);

`ifdef UNO_SEQ_CTRL_PERF_EN
  logic [15:0] pbusy_q, pstall_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || perf_clr_i) begin
      pbusy_q  <= '0;
      pstall_q <= '0;
    end else begin
      if (busy_o && pbusy_q != 16'hFFFF) pbusy_q <= pbusy_q + 16'd1;
      if (state_q == MAC_RUN && !opnd_valid_i && pstall_q != 16'hFFFF)
        pstall_q <= pstall_q + 16'd1;
    end
  end

  assign perf_busy_o  = pbusy_q;
  assign perf_stall_o = pstall_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr_i;
  assign perf_busy_o     = '0;
  assign perf_stall_o    = '0;
`endif
endmodule

// File: tb/tb_uno_seq_ctrl.sv
// Randomized bench for uno_seq_ctrl: per-cycle expectations come from a
// transaction-level model (term counts, beat counts, cycle budgets).
module tb_uno_seq_ctrl;
  localparam int DW = 12, CNT_W = 4, MAC_LAT = 1, DEF_ORDER = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_op = '0;
  logic [CNT_W-1:0]  cfg_order = '0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = '0;
  logic [CNT_W-1:0]  cmd_len = '0;
  logic              opnd_valid = 1'b0;
  logic              opnd_ready;
  logic [1:0]        pe_op;
  logic              pe_first_cycle, pe_last_cycle, pe_acc_en, pe_zero_x;
  logic [CNT_W+1:0]  pe_coeff_addr;
  logic [2*DW-1:0]   pe_result = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [2*DW-1:0]   res_data;
  logic              busy;
  logic              perf_clr = 1'b0;
  logic [15:0]       perf_busy, perf_stall;

  uno_seq_ctrl #(.DW(DW), .CNT_W(CNT_W), .MAC_LAT(MAC_LAT), .DEF_ORDER(DEF_ORDER)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cfg_we_i(cfg_we), .cfg_op_i(cfg_op), .cfg_order_i(cfg_order),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op), .cmd_len_i(cmd_len),
    .opnd_valid_i(opnd_valid), .opnd_ready_o(opnd_ready), .pe_op_o(pe_op),
    .pe_first_cycle_o(pe_first_cycle), .pe_last_cycle_o(pe_last_cycle), .pe_acc_en_o(pe_acc_en),
    .pe_zero_x_o(pe_zero_x), .pe_coeff_addr_o(pe_coeff_addr), .pe_result_i(pe_result),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data), .busy_o(busy),
    .perf_clr_i(perf_clr), .perf_busy_o(perf_busy), .perf_stall_o(perf_stall)
  );

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int model_ord[4] = '{DEF_ORDER, DEF_ORDER, DEF_ORDER, DEF_ORDER};
  int m_busy = 0, m_stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag, input logic [1:0] op);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_opnd_ready"}, opnd_ready, 0);
    chk({tag, "_ctl"}, {pe_first_cycle, pe_last_cycle, pe_acc_en, pe_zero_x}, 4'b0001);
    chk({tag, "_addr"}, pe_coeff_addr, 0);
    chk({tag, "_pe_op"}, pe_op, op);
  endtask

  task automatic check_perf(input string tag);
`ifdef UNO_SEQ_CTRL_PERF_EN
    chk({tag, "_perf_busy"}, perf_busy, m_busy);
    chk({tag, "_perf_stall"}, perf_stall, m_stall);
`else
    chk({tag, "_perf_busy"}, perf_busy, 0);
    chk({tag, "_perf_stall"}, perf_stall, 0);
`endif
  endtask

  task automatic cfg_write(input logic [1:0] op, input logic [3:0] ord);
    @(negedge clk); cfg_we = 1; cfg_op = op; cfg_order = ord;
    @(negedge clk); cfg_we = 0;
    if (op != 0) model_ord[op] = (ord < 2) ? 2 : int'(ord);
  endtask

  // One full command: accept, issue phase, drain, result hold, handshake.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] len, input int hold,
                        input int pvpct, input logic [31:0] pat, input bit use_pat,
                        input bit cfg_same);
    int T, beats, guard, acc_cyc, last_cyc;
    bit ov;
    logic [2*DW-1:0] exp_res;
    logic [3:0] new_ord;
    @(negedge clk);
    cmd_valid = 1; cmd_op = op; cmd_len = len;
    T = model_ord[op];
    new_ord = 4'($urandom);
    if (cfg_same && op != 0) begin cfg_we = 1; cfg_op = op; cfg_order = new_ord; end
    #1 chk("acc_ready", cmd_ready, 1);
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 0; cfg_we = 0;
    if (cfg_same && op != 0) model_ord[op] = (new_ord < 2) ? 2 : int'(new_ord);
    last_cyc = cyc;
    if (op != 0) begin
      for (int k = 0; k < T; k++) begin
        pe_result = 24'($urandom); res_ready = 1'($urandom);
        cmd_valid = 1'($urandom); cmd_op = 2'($urandom);
        #1;
        chk("nl_busy", busy, 1);
        chk("nl_cmd_ready", cmd_ready, 0);
        chk("nl_first", pe_first_cycle, k == 0);
        chk("nl_last", pe_last_cycle, k == T - 1);
        chk("nl_addr", pe_coeff_addr, {op, 4'(T - 1 - k)});
        chk("nl_zx_acc", {pe_zero_x, pe_acc_en, opnd_ready}, 3'b000);
        chk("nl_pe_op", pe_op, op);
        m_busy++;
        @(negedge clk);
      end
    end else begin
      beats = 0; guard = 0;
      while (beats < int'(len) + 1 && guard < 200) begin
        ov = use_pat ? pat[guard] : ($urandom_range(99) < pvpct);
        opnd_valid = ov; pe_result = 24'($urandom); res_ready = 1'($urandom);
        cmd_valid = 1'($urandom);
        #1;
        chk("mac_opnd_ready", opnd_ready, 1);
        chk("mac_zero_x", pe_zero_x, !ov);
        chk("mac_acc_en", pe_acc_en, beats > 0);
        chk("mac_fl", {pe_first_cycle, pe_last_cycle}, 2'b00);
        chk("mac_busy", busy, 1);
        m_busy++;
        if (!ov) m_stall++;
        if (ov) begin beats++; last_cyc = cyc; end
        guard++;
        @(negedge clk);
      end
      opnd_valid = 0;
      if (guard >= 200) chk("mac_guard", 0, 1);
    end
    exp_res = '0;
    for (int d = 0; d < MAC_LAT; d++) begin
      pe_result = 24'($urandom); cmd_valid = 1'($urandom);
      #1;
      chk("drn_ctl", {pe_zero_x, pe_acc_en, res_valid, busy}, 4'b1001);
      exp_res = pe_result;
      m_busy++;
      @(negedge clk);
    end
    if (op != 0) chk("nl_latency", cyc - acc_cyc, T + 1 + MAC_LAT);
    else         chk("mac_latency", cyc - last_cyc, 1 + MAC_LAT);
    for (int h = 0; h < hold; h++) begin
      res_ready = 0; pe_result = 24'($urandom);
      cmd_valid = 1'($urandom); cmd_op = 2'($urandom);
      #1;
      chk("done_valid", res_valid, 1);
      chk("done_data", res_data, exp_res);
      chk("done_cmd_ready", cmd_ready, 0);
      m_busy++;
      @(negedge clk);
    end
    res_ready = 1; cmd_valid = 0;
    #1;
    chk("hs_valid", res_valid, 1);
    chk("hs_data", res_data, exp_res);
    m_busy++;
    @(negedge clk);
    res_ready = 0;
    #1;
    check_idle("post", op);
    check_perf("post");
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 check_idle("reset", 2'b00);
    chk("reset_res_data", res_data, 0);
    check_perf("reset");
    rst_n = 1;

    // exp, T=4: addresses 3..0, result 6 cycles after accept
    cfg_write(2'b10, 4'd4);
    do_cmd(2'b10, 4'd0, 0, 100, 0, 0, 0);
    // MAC len 4, no stalls
    do_cmd(2'b00, 4'd3, 1, 100, 0, 0, 0);
    // MAC len 3 with stall pattern 1,0,0,1,1
    m_stall = 0; m_busy = 0;
    @(negedge clk); perf_clr = 1; @(negedge clk); perf_clr = 0;
    do_cmd(2'b00, 4'd2, 0, 0, 32'b11001, 1, 0);
    // log with clamped order
    cfg_write(2'b11, 4'd0);
    do_cmd(2'b11, 4'd0, 0, 100, 0, 0, 0);
    // long result hold with ignored command pulses
    do_cmd(2'b01, 4'd0, 5, 100, 0, 0, 0);
    // max MAC length, and same-cycle cfg write on div
    do_cmd(2'b00, 4'd15, 2, 70, 0, 0, 0);
    do_cmd(2'b01, 4'd0, 1, 100, 0, 0, 1);
    do_cmd(2'b01, 4'd0, 0, 100, 0, 0, 0);
    cfg_write(2'b00, 4'd9);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(3) == 0) cfg_write(2'($urandom), 4'($urandom));
      do_cmd(2'($urandom), 4'($urandom), $urandom_range(3), $urandom_range(30, 100),
             0, 0, 1'($urandom));
    end

    // reset in the middle of an exp command at k=1
    @(negedge clk); cmd_valid = 1; cmd_op = 2'b10; cmd_len = 0;
    @(negedge clk); cmd_valid = 0;
    #1 chk("rst_k0_first", pe_first_cycle, 1);
    @(negedge clk);
    #1 chk("rst_k1_addr", pe_coeff_addr, {2'b10, 4'(model_ord[2] - 2)});
    rst_n = 0;
    @(negedge clk); rst_n = 1;
    model_ord = '{DEF_ORDER, DEF_ORDER, DEF_ORDER, DEF_ORDER};
    m_busy = 0; m_stall = 0;
    #1 check_idle("rst_mid", 2'b00);
    check_perf("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("rst_no_res", {res_valid, busy}, 2'b00);
    end
    do_cmd(2'b10, 4'd0, 0, 100, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
